// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bus between the CPU core (master) and alu_seq (slave).
//   req_valid/req_ready handshake; req_op/req_a/req_b/req_cin operands.
//   rsp_valid one-cycle strobe; rsp_a/rsp_b results; rsp_cy/rsp_ov new flags.
interface alu_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       req_cin;
  logic       rsp_valid;
  logic [7:0] rsp_a;
  logic [7:0] rsp_b;
  logic       rsp_cy;
  logic       rsp_ov;
  modport master(output req_valid, req_op, req_a, req_b, req_cin,
                 input req_ready, rsp_valid, rsp_a, rsp_b, rsp_cy, rsp_ov);
  modport slave(input req_valid, req_op, req_a, req_b, req_cin,
                output req_ready, rsp_valid, rsp_a, rsp_b, rsp_cy, rsp_ov);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequencing front end for the shared 8051 ALU; iterative MUL AB / DIV AB.
//   clk, rst_n (sync, active-low); bus: alu_seq_if.slave request/response;
//   alu_en/alu_op/alu_a/alu_b/alu_cin to the ALU, alu_ans/alu_cout from it; busy = not idle.
//   ALU_SEQ_DA_EN: when defined, DA A is computed locally instead of by the ALU.
module alu_seq #(
  parameter logic [4:0] MUL_OP = 5'h05,
  parameter logic [4:0] DIV_OP = 5'h06,
  parameter logic [4:0] DA_OP  = 5'h07
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus,
  output logic       alu_en,
  output logic [4:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_ans,
  input  logic       alu_cout,
  output logic       busy
);
`ifdef ALU_SEQ_DA_EN
  localparam bit DA_EN = 1'b1;
`else
  localparam bit DA_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, EXEC, MUL_IT, DIV_IT, RESP} state_t;
  state_t state, state_nxt;
  logic [4:0] op_r;
  logic [7:0] a_r, b_r, rsp_a, rsp_b, ex_ans, ex_b, div_d, da_ans;
  logic cin_r, rsp_cy, rsp_ov, accept, last, div_op, da_sel, div_ge, borrow, da_hi, ex_cy, ex_ov;
  logic [3:0] cnt;
  logic [15:0] acc, mul_nxt, div_nxt;
  logic [8:0] mul_sum, div_t, da_s1;
  assign accept = bus.req_valid && state == IDLE;
  assign last = cnt == 4'd7;
  assign div_op = op_r == DIV_OP;
  assign da_sel = DA_EN && op_r == DA_OP;
  assign alu_op = op_r;
  assign alu_a = a_r;
  assign alu_b = b_r;
  assign alu_cin = cin_r;
  assign bus.rsp_a = rsp_a;
  assign bus.rsp_b = rsp_b;
  assign bus.rsp_cy = rsp_cy;
  assign bus.rsp_ov = rsp_ov;
  // acc holds {partial product high, multiplier} for MUL, {remainder, dividend/quotient} for DIV
  assign mul_sum = {1'b0, acc[15:8]} + (acc[0] ? {1'b0, a_r} : 9'd0);
  assign mul_nxt = {mul_sum, acc[7:1]};
  assign div_t = {acc[15:8], acc[7]};
  assign div_ge = div_t >= {1'b0, b_r};
  assign div_d = div_ge ? 8'(div_t - {1'b0, b_r}) : div_t[7:0];
  assign div_nxt = {div_d, acc[6:0], div_ge};
  assign da_s1 = {1'b0, a_r} + ((a_r[3:0] > 4'd9 || b_r[0]) ? 9'd6 : 9'd0);
  assign da_hi = da_s1[7:4] > 4'd9 || cin_r || da_s1[8];
  assign da_ans = da_s1[7:0] + (da_hi ? 8'h60 : 8'h00);
  assign borrow = {1'b0, a_r} < {1'b0, b_r} + 9'(cin_r);
  // EXEC only sees DIV_OP when the divisor is zero
  always_comb begin
    ex_ans = div_op ? 8'hFF : da_sel ? da_ans : alu_ans;
    ex_b = div_op ? a_r : b_r;
    ex_cy = (op_r == 5'h00 || op_r == 5'h01 || op_r == 5'h0F || op_r == 5'h11) ? alu_cout :
            op_r == 5'h04 ? borrow : div_op ? 1'b0 : da_sel ? (cin_r | da_hi) : cin_r;
    ex_ov = div_op ? 1'b1 :
            (op_r == 5'h00 || op_r == 5'h01) ? (a_r[7] == b_r[7]) && (ex_ans[7] != a_r[7]) :
            op_r == 5'h04 ? (a_r[7] != b_r[7]) && (ex_ans[7] != a_r[7]) : 1'b0;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.req_op == MUL_OP ? MUL_IT :
                                       (bus.req_op == DIV_OP && bus.req_b != 8'h00) ? DIV_IT : EXEC;
      EXEC:    state_nxt = RESP;
      MUL_IT,
      DIV_IT:  if (last) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    busy = state != IDLE;
    alu_en = state == EXEC && !div_op && !da_sel;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      cin_r <= 1'b0;
      cnt <= '0;
      acc <= '0;
      rsp_a <= '0;
      rsp_b <= '0;
      rsp_cy <= 1'b0;
      rsp_ov <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= bus.req_op;
        a_r <= bus.req_a;
        b_r <= bus.req_b;
        cin_r <= bus.req_cin;
        cnt <= '0;
        acc <= {8'h00, bus.req_op == MUL_OP ? bus.req_b : bus.req_a};
      end else if (state == MUL_IT || state == DIV_IT) begin
        cnt <= cnt == 4'd8 ? cnt : cnt + 4'd1;
        acc <= state == MUL_IT ? mul_nxt : div_nxt;
      end
      if (state == EXEC) begin
        rsp_a <= ex_ans;
        rsp_b <= ex_b;
        rsp_cy <= ex_cy;
        rsp_ov <= ex_ov;
      end else if (state == MUL_IT && last) begin
        rsp_a <= mul_nxt[7:0];
        rsp_b <= mul_nxt[15:8];
        rsp_cy <= 1'b0;
        rsp_ov <= mul_nxt[15:8] != 8'h00;
      end else if (state == DIV_IT && last) begin
        rsp_a <= div_nxt[7:0];
        rsp_b <= div_nxt[15:8];
        rsp_cy <= 1'b0;
        rsp_ov <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq with a small behavioural ALU.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_en, alu_cin, alu_cout, busy;
  logic [4:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_ans;
  int n_chk = 0;
  int n_err = 0;
  alu_seq_if bus();
  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_ans(alu_ans), .alu_cout(alu_cout), .busy(busy)
  );
  always #5 clk = ~clk;
  always_comb begin
    {alu_cout, alu_ans} = 9'h000;
    case (alu_op)
      5'h00: {alu_cout, alu_ans} = {1'b0, alu_a} + {1'b0, alu_b};
      5'h01: {alu_cout, alu_ans} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_cin);
      5'h02: {alu_cout, alu_ans} = {1'b0, alu_a & alu_b};
      5'h04: {alu_cout, alu_ans} = {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_cin);
      default: {alu_cout, alu_ans} = 9'h000;
    endcase
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input int lat, input logic [7:0] ea, input logic [7:0] eb,
                        input logic ecy, input logic eov, input logic een);
    int w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.req_ready) check({tag, "_ready_timeout"}, 16'(bus.req_ready), 16'd1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_cin = cin;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (lat > 3 && k == 2) begin
        bus.req_valid = 1'b1;
        bus.req_op = 5'h00;
        bus.req_a = 8'h55;
        bus.req_b = 8'hAA;
      end
      if (k == 1) begin
        check({tag, "_alu_en_t1"}, 16'(alu_en), 16'(een));
        check({tag, "_busy_t1"}, 16'(busy), 16'd1);
      end
      if (k == lat - 1) check({tag, "_early_valid"}, 16'(bus.rsp_valid), 16'd0);
      if (k == lat) begin
        check({tag, "_valid"}, 16'(bus.rsp_valid), 16'd1);
        check({tag, "_ready_low"}, 16'(bus.req_ready), 16'd0);
        check({tag, "_alu_en_off"}, 16'(alu_en), 16'd0);
        check({tag, "_a"}, 16'(bus.rsp_a), 16'(ea));
        check({tag, "_b"}, 16'(bus.rsp_b), 16'(eb));
        check({tag, "_cy"}, 16'(bus.rsp_cy), 16'(ecy));
        check({tag, "_ov"}, 16'(bus.rsp_ov), 16'(eov));
      end
    end
    @(negedge clk);
    check({tag, "_valid_drop"}, 16'(bus.rsp_valid), 16'd0);
    check({tag, "_ready_back"}, 16'(bus.req_ready), 16'd1);
  endtask
  initial begin
    int hits;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 16'(bus.req_ready), 16'd1);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_valid", 16'(bus.rsp_valid), 16'd0);
    check("rst_rsp", {bus.rsp_a, bus.rsp_b}, 16'h0000);
    check("rst_alu", {3'b0, alu_en, alu_cin, alu_op, 6'b0}, 16'h0000);
    check("rst_alu_ab", {alu_a, alu_b}, 16'h0000);
    run_op("add", 5'h00, 8'h7F, 8'h01, 1'b0, 2, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
    run_op("addc", 5'h01, 8'hFF, 8'h00, 1'b1, 2, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("subb", 5'h04, 8'h10, 8'h20, 1'b1, 2, 8'hEF, 8'h20, 1'b1, 1'b0, 1'b1);
    run_op("anl", 5'h02, 8'hF0, 8'h3C, 1'b1, 2, 8'h30, 8'h3C, 1'b1, 1'b0, 1'b1);
    run_op("mul", 5'h05, 8'hC8, 8'h02, 1'b1, 9, 8'h90, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op("mul_max", 5'h05, 8'hFF, 8'hFF, 1'b0, 9, 8'h01, 8'hFE, 1'b0, 1'b1, 1'b0);
    run_op("mul_small", 5'h05, 8'h03, 8'h04, 1'b0, 9, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("div", 5'h06, 8'hFB, 8'h12, 1'b1, 9, 8'h0D, 8'h11, 1'b0, 1'b0, 1'b0);
    run_op("div_lt", 5'h06, 8'h07, 8'h09, 1'b0, 9, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0);
    run_op("div0", 5'h06, 8'h33, 8'h00, 1'b1, 2, 8'hFF, 8'h33, 1'b0, 1'b1, 1'b0);
`ifdef ALU_SEQ_DA_EN
    run_op("da", 5'h07, 8'h9B, 8'h00, 1'b0, 2, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
`else
    run_op("da", 5'h07, 8'h9B, 8'h00, 1'b0, 2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
`endif
    bus.req_valid = 1'b1;
    bus.req_op = 5'h05;
    bus.req_a = 8'h21;
    bus.req_b = 8'h43;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_busy", 16'(busy), 16'd1);
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      hits += int'(bus.rsp_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_ready", 16'(bus.req_ready), 16'd1);
    check("abort_busy_low", 16'(busy), 16'd0);
    check("abort_rsp", {bus.rsp_a, bus.rsp_b}, 16'h0000);
    check("abort_flags", {14'b0, bus.rsp_cy, bus.rsp_ov}, 16'h0000);
    check("abort_alu", {alu_a, 3'b0, alu_op}, 16'h0000);
    repeat (12) begin
      @(negedge clk);
      hits += int'(bus.rsp_valid);
    end
    check("abort_no_valid", 16'(hits), 16'd0);
    run_op("add_after", 5'h00, 8'h12, 8'h34, 1'b0, 2, 8'h46, 8'h34, 1'b0, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
